// File: rtl/ex_branch_resolve_if.sv
// EX-stage control bundle between the ID/EX register, the branch resolver and the fetch PC mux.
// Optional BRANCH_STATS_EN adds the branch statistics counters.
interface ex_branch_resolve_if #(
    parameter int DATA_W = 16
);
    // Handshake: an EX slot is consumed on a rising edge where ex_valid=1 and stall=0;
    // stall acts as the inverse of ready and freezes the slot in place.
    logic              stall;
    logic              ex_valid;
    logic [3:0]        ex_cond;
    logic              ex_cc_we;
    logic              ex_jmp;
    logic              ex_bxx;
    logic              ex_halt;
    logic [DATA_W-1:0] alu_result;
    logic [3:0]        alu_flags;
    logic              pc_load;
    logic [DATA_W-1:0] pc_target;
    logic              flush_front;
    logic [3:0]        cc_flags;
    logic              ex_squash;
    logic              halted;
    logic [1:0]        dbg_state;
`ifdef BRANCH_STATS_EN
    logic [15:0]       br_taken_cnt;
    logic [15:0]       br_nt_cnt;
`endif

    modport master (
        output stall, ex_valid, ex_cond, ex_cc_we, ex_jmp, ex_bxx, ex_halt,
               alu_result, alu_flags,
        input  pc_load, pc_target, flush_front, cc_flags, ex_squash, halted, dbg_state
`ifdef BRANCH_STATS_EN
        , input br_taken_cnt, br_nt_cnt
`endif
    );

    modport slave (
        input  stall, ex_valid, ex_cond, ex_cc_we, ex_jmp, ex_bxx, ex_halt,
               alu_result, alu_flags,
        output pc_load, pc_target, flush_front, cc_flags, ex_squash, halted, dbg_state
`ifdef BRANCH_STATS_EN
        , output br_taken_cnt, br_nt_cnt
`endif
    );
endinterface

// File: rtl/ex_branch_resolve.sv
// Execute-stage branch resolver: NZCV register, condition evaluation, registered redirect,
// wrong-path squash and halt latch. Define BRANCH_STATS_EN for taken/not-taken counters.
module ex_branch_resolve #(
    parameter int DATA_W       = 16,
    parameter int FLUSH_CYCLES = 2
) (
    input logic               clk,
    input logic               rst,
    ex_branch_resolve_if.slave bus
);
    localparam int CNT_W = (FLUSH_CYCLES < 2) ? 1 : $clog2(FLUSH_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  flush_cnt;
    logic [3:0]        cc_q;
    logic              pc_load_q;
    logic [DATA_W-1:0] pc_target_q;
    logic              halted_q;
    logic              act;
    logic              cond_ok;
    logic              taken;

    function automatic logic cond_true(input logic [3:0] cond, input logic [3:0] nzcv);
        logic n, z, c, v;
        {n, z, c, v} = nzcv;
        case (cond)
            4'd0:    cond_true = 1'b1;
            4'd1:    cond_true = z;
            4'd2:    cond_true = !z;
            4'd3:    cond_true = c;
            4'd4:    cond_true = !c;
            4'd5:    cond_true = n;
            4'd6:    cond_true = !n;
            4'd7:    cond_true = v;
            4'd8:    cond_true = !v;
            4'd9:    cond_true = c & !z;
            4'd10:   cond_true = !c | z;
            4'd11:   cond_true = (n == v);
            4'd12:   cond_true = (n != v);
            4'd13:   cond_true = !z & (n == v);
            4'd14:   cond_true = z | (n != v);
            default: cond_true = 1'b0;
        endcase
    endfunction

    // Branches compare against the registered flags, so a same-slot CC write is never seen.
    assign act     = (state == ST_RUN) & bus.ex_valid & !bus.stall;
    assign cond_ok = cond_true(bus.ex_cond, cc_q);
    assign taken   = act & (bus.ex_jmp | (bus.ex_bxx & cond_ok));

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_RUN;
            flush_cnt   <= '0;
            cc_q        <= 4'b0000;
            pc_load_q   <= 1'b0;
            pc_target_q <= '0;
            halted_q    <= 1'b0;
        end else begin
            pc_load_q <= 1'b0;
            if (!bus.stall) begin
                case (state)
                    ST_RUN: begin
                        if (bus.ex_valid) begin
                            if (bus.ex_cc_we) cc_q <= bus.alu_flags;
                            if (bus.ex_halt) begin
                                state    <= ST_HALT;
                                halted_q <= 1'b1;
                            end else if (taken) begin
                                state       <= ST_FLUSH;
                                flush_cnt   <= CNT_W'(FLUSH_CYCLES);
                                pc_load_q   <= 1'b1;
                                pc_target_q <= bus.alu_result;
                            end
                        end
                    end
                    ST_FLUSH: begin
                        flush_cnt <= flush_cnt - 1'b1;
                        if (flush_cnt == CNT_W'(1)) state <= ST_RUN;
                    end
                    default: state <= ST_HALT;
                endcase
            end
        end
    end

    assign bus.pc_load     = pc_load_q;
    assign bus.flush_front = pc_load_q;
    assign bus.pc_target   = pc_target_q;
    assign bus.cc_flags    = cc_q;
    assign bus.halted      = halted_q;
    assign bus.dbg_state   = state;
    assign bus.ex_squash   = (state != ST_RUN) & bus.ex_valid;

`ifdef BRANCH_STATS_EN
    logic [15:0] taken_cnt_q;
    logic [15:0] nt_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            taken_cnt_q <= '0;
            nt_cnt_q    <= '0;
        end else begin
            if (taken & bus.ex_bxx & (taken_cnt_q != 16'hFFFF)) taken_cnt_q <= taken_cnt_q + 1'b1;
            if (act & bus.ex_bxx & !taken & (nt_cnt_q != 16'hFFFF)) nt_cnt_q <= nt_cnt_q + 1'b1;
        end
    end

    assign bus.br_taken_cnt = taken_cnt_q;
    assign bus.br_nt_cnt    = nt_cnt_q;
`endif
endmodule

// File: tb/tb_ex_branch_resolve.sv
// Directed bench for ex_branch_resolve: reset, CC update, taken/not-taken, stall, halt, reset mid-flush.
module tb_ex_branch_resolve;
  logic clk;
  logic rst;
  int n_cmp;
  int n_err;
  logic [15:0] exp_q[$];

  ex_branch_resolve_if #(.DATA_W(16)) bus ();

  ex_branch_resolve #(.DATA_W(16), .FLUSH_CYCLES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic valid, input logic [3:0] cond, input logic cc_we,
                       input logic jmp, input logic bxx, input logic halt,
                       input logic [15:0] res, input logic [3:0] flags);
    bus.ex_valid   = valid;
    bus.ex_cond    = cond;
    bus.ex_cc_we   = cc_we;
    bus.ex_jmp     = jmp;
    bus.ex_bxx     = bxx;
    bus.ex_halt    = halt;
    bus.alu_result = res;
    bus.alu_flags  = flags;
  endtask

  task automatic idle();
    drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 4'b0000);
  endtask

  // Redirect scoreboard: targets expected in issue order.
  task automatic check_redirect(input string tag);
    logic [15:0] want;
    check({tag, "_pc_load"}, bus.pc_load, 1'b1);
    check({tag, "_flush"}, bus.flush_front, 1'b1);
    want = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
    check({tag, "_target"}, bus.pc_target, want);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    bus.stall = 1'b0;
    idle();

    // T1 reset
    step();
    check("rst_cc", bus.cc_flags, 4'b0000);
    check("rst_halted", bus.halted, 1'b0);
    check("rst_pc_load", bus.pc_load, 1'b0);
    check("rst_target", bus.pc_target, 16'h0000);
    check("rst_state", bus.dbg_state, 2'd0);
    rst = 1'b0;

    // T2 CC write then taken BEQ
    drive(1'b1, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 4'b0100);
    step();
    check("t2_cc", bus.cc_flags, 4'b0100);
    drive(1'b1, 4'd1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0040, 4'b0000);
    exp_q.push_back(16'h0040);
    step();
    check_redirect("t2");
    drive(1'b1, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 4'b1111);
    #1 check("t2_squash1", bus.ex_squash, 1'b1);
    step();
    check("t2_pulse_once", bus.pc_load, 1'b0);
    check("t2_cc_kept", bus.cc_flags, 4'b0100);
    #1 check("t2_squash2", bus.ex_squash, 1'b1);
    step();
    drive(1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 4'b0000);
    #1 check("t2_no_squash", bus.ex_squash, 1'b0);
    check("t2_state_run", bus.dbg_state, 2'd0);

    // T3 clear flags, BEQ not taken
    drive(1'b1, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 4'b0000);
    step();
    check("t3_cc", bus.cc_flags, 4'b0000);
    drive(1'b1, 4'd1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0080, 4'b0000);
    step();
    check("t3_pc_load", bus.pc_load, 1'b0);
    check("t3_state", bus.dbg_state, 2'd0);
    drive(1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 4'b0000);
    #1 check("t3_squash", bus.ex_squash, 1'b0);

    // Signed conditions with N=1,V=0: LT taken, GE not, NV never
    drive(1'b1, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 4'b1000);
    step();
    drive(1'b1, 4'd12, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0100, 4'b0000);
    exp_q.push_back(16'h0100);
    step();
    check_redirect("lt");
    idle();
    step();
    check("lt_state_flush", bus.dbg_state, 2'd1);
    step();
    check("lt_back_run", bus.dbg_state, 2'd0);
    drive(1'b1, 4'd11, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0200, 4'b0000);
    step();
    check("ge_not_taken", bus.pc_load, 1'b0);
    drive(1'b1, 4'd15, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0300, 4'b0000);
    step();
    check("nv_not_taken", bus.pc_load, 1'b0);

    // Illegal BXX+CC_WE: flags written, branch uses old flags (Z=0 -> EQ false)
    drive(1'b1, 4'd1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0400, 4'b0100);
    step();
    check("illegal_pc_load", bus.pc_load, 1'b0);
    check("illegal_cc", bus.cc_flags, 4'b0100);

    // T4 JMP held by stall for 3 cycles
    bus.stall = 1'b1;
    drive(1'b1, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h1234, 4'b0000);
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("t4_stall_%0d", i), bus.pc_load, 1'b0);
    end
    bus.stall = 1'b0;
    exp_q.push_back(16'h1234);
    step();
    check_redirect("t4");
    idle();
    step();
    check("t4_pulse_once", bus.pc_load, 1'b0);
    step();

    // T5 halt, then a CC-writing ADD is squashed
    drive(1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 4'b0000);
    step();
    check("t5_halted", bus.halted, 1'b1);
    check("t5_state", bus.dbg_state, 2'd2);
    drive(1'b1, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 4'b1111);
    #1 check("t5_squash", bus.ex_squash, 1'b1);
    step();
    check("t5_cc_kept", bus.cc_flags, 4'b0100);
    drive(1'b1, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0500, 4'b0000);
    step();
    check("t5_no_jmp", bus.pc_load, 1'b0);
    check("t5_still_halted", bus.halted, 1'b1);

    // T6 reset during FLUSH
    rst = 1'b1;
    idle();
    step();
    rst = 1'b0;
    check("t6_unhalted", bus.halted, 1'b0);
    drive(1'b1, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0055, 4'b0000);
    exp_q.push_back(16'h0055);
    step();
    check_redirect("t6");
    rst = 1'b1;
    drive(1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 4'b0000);
    step();
    rst = 1'b0;
    check("t6_state", bus.dbg_state, 2'd0);
    check("t6_pc_load", bus.pc_load, 1'b0);
    #1 check("t6_squash", bus.ex_squash, 1'b0);
    check("exp_q_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
